// File: rtl/gr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gr_pkg
// Description : Shared constants for the gr0040 peripheral slice: interrupt
//               controller register map, default vector placement and a
//               small index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gr_pkg;

    // Interrupt controller register map (reg_ad values)
    localparam logic [1:0] INTC_ENABLE    = 2'd0;
    localparam logic [1:0] INTC_PENDING   = 2'd1;
    localparam logic [1:0] INTC_INSERVICE = 2'd2;
    localparam logic [1:0] INTC_SOFT      = 2'd3;

    // Default vector table placement
    localparam logic [15:0] GR_VEC_BASE   = 16'h0020;
    localparam logic [15:0] GR_VEC_STRIDE = 16'h0004;

    // Width of an index into an n-entry vector; never narrower than one bit.
    function automatic int gr_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : gr_pkg
`default_nettype wire

// File: rtl/gr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : gr_prio_enc
// Description : Lowest-index-wins priority encoder. Reports whether any
//               request bit is set and the index of the lowest one set.
//               Index reads 0 when no bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module gr_prio_enc
    import gr_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = gr_idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    // Scan from the top so the lowest set bit is the last (winning) write
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_valid = |i_req;

endmodule : gr_prio_enc
`default_nettype wire

// File: rtl/gr_intc.sv
`default_nettype none
// ============================================================================
// Module      : gr_intc
// Description : Vectored interrupt controller for the gr0040 core. Collects
//               NIRQ level/edge sources, masks them with ENABLE, picks the
//               lowest-index request, issues irq_take/irq_vector and tracks
//               in-service state retired by iret_detected.
//               Build option: define GR_INTC_NEST_EN to allow a higher
//               priority source to pre-empt one already in service; without
//               it at most one interrupt is in service at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module gr_intc
    import gr_pkg::*;
#(
    parameter int          NIRQ       = 8,
    parameter logic [15:0] EDGE       = 16'h0000,
    parameter logic [15:0] VEC_BASE   = GR_VEC_BASE,
    parameter logic [15:0] VEC_STRIDE = GR_VEC_STRIDE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            int_en,
    input  logic            iret_detected,
    output logic            irq_take,
    output logic [15:0]     irq_vector,
    input  logic            reg_sel,
    input  logic            reg_we,
    input  logic [1:0]      reg_ad,
    input  logic [15:0]     reg_wdata,
    output logic [15:0]     reg_rdata
);

    localparam int              c_idx_w = gr_idx_w(NIRQ);
    localparam logic [NIRQ-1:0] c_edge  = EDGE[NIRQ-1:0];

    // Architectural state
    logic [NIRQ-1:0]    r_en;
    logic [NIRQ-1:0]    r_pend;
    logic [NIRQ-1:0]    r_insvc;
    logic [NIRQ-1:0]    r_irq_q;
    logic               r_req_v;
    logic [c_idx_w-1:0] r_req_id;

    // Combinational helpers
    logic               w_cand_v;
    logic [c_idx_w-1:0] w_cand_id;
    logic               w_ins_v;
    logic [c_idx_w-1:0] w_ins_id;
    logic               w_elig;
    logic               w_take;
    logic [NIRQ-1:0]    w_take_oh;
    logic [NIRQ-1:0]    w_ins_oh;
    logic [NIRQ-1:0]    w_wdata;
    logic               w_wr_en;
    logic               w_wr_pend;
    logic               w_wr_soft;
    logic [NIRQ-1:0]    w_pend_set;
    logic [NIRQ-1:0]    w_pend_clr;
    logic [NIRQ-1:0]    w_pend_nxt;
    logic [NIRQ-1:0]    w_ins_nxt;
    logic [15:0]        w_id16;
    logic               w_unused_wdata;

    // Request candidate: lowest enabled pending source
    gr_prio_enc #(.N(NIRQ), .IW(c_idx_w)) u_req_enc (
        .i_req   (r_pend & r_en),
        .o_valid (w_cand_v),
        .o_idx   (w_cand_id)
    );

    // Highest-priority source currently in service
    gr_prio_enc #(.N(NIRQ), .IW(c_idx_w)) u_ins_enc (
        .i_req   (r_insvc),
        .o_valid (w_ins_v),
        .o_idx   (w_ins_id)
    );

`ifdef GR_INTC_NEST_EN
    // Pre-empt only with a strictly higher-priority (lower-index) source
    assign w_elig = ~w_ins_v | (r_req_id < w_ins_id);
`else
    // Single level: nothing may be taken while anything is in service
    assign w_elig = ~w_ins_v;
`endif

    assign w_take     = r_req_v & int_en & ~rst & w_elig;
    assign irq_take   = w_take;
    assign w_id16     = 16'(r_req_id);
    assign irq_vector = w_take ? (VEC_BASE + w_id16 * VEC_STRIDE) : 16'h0000;

    assign w_wdata   = reg_wdata[NIRQ-1:0];
    assign w_wr_en   = reg_sel & reg_we & (reg_ad == INTC_ENABLE);
    assign w_wr_pend = reg_sel & reg_we & (reg_ad == INTC_PENDING);
    assign w_wr_soft = reg_sel & reg_we & (reg_ad == INTC_SOFT);

    // Bits of the write bus above NIRQ are ignored by every register
    assign w_unused_wdata = ^reg_wdata;

    // One-hot decodes of the taken source and the source being retired
    always_comb begin
        w_take_oh = '0;
        w_ins_oh  = '0;
        if (w_take) begin
            w_take_oh[r_req_id] = 1'b1;
        end
        if (iret_detected && w_ins_v) begin
            w_ins_oh[w_ins_id] = 1'b1;
        end
    end

    // Next pending: edge sources latch (set beats clear), level sources follow irq_in
    always_comb begin
        w_pend_set = (irq_in & ~r_irq_q) | (w_wr_soft ? w_wdata : '0);
        w_pend_clr = w_take_oh | (w_wr_pend ? w_wdata : '0);
        w_pend_nxt = (c_edge & ((r_pend & ~w_pend_clr) | w_pend_set))
                   | (~c_edge & irq_in);
    end

    // Next in-service: retire on iret before marking the newly taken source
    always_comb begin
        w_ins_nxt = (r_insvc & ~w_ins_oh) | w_take_oh;
    end

    // State registers; a take suppresses the request for the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= '0;
            r_pend   <= '0;
            r_insvc  <= '0;
            r_irq_q  <= '0;
            r_req_v  <= 1'b0;
            r_req_id <= '0;
        end else begin
            if (w_wr_en) begin
                r_en <= w_wdata;
            end
            r_pend   <= w_pend_nxt;
            r_insvc  <= w_ins_nxt;
            r_irq_q  <= irq_in;
            r_req_v  <= w_take ? 1'b0 : w_cand_v;
            r_req_id <= w_cand_id;
        end
    end

    // Register read mux; unused upper bits read as zero, SOFT reads zero
    always_comb begin
        reg_rdata = 16'h0000;
        case (reg_ad)
            INTC_ENABLE:    reg_rdata[NIRQ-1:0] = r_en;
            INTC_PENDING:   reg_rdata[NIRQ-1:0] = r_pend;
            INTC_INSERVICE: reg_rdata[NIRQ-1:0] = r_insvc;
            default:        reg_rdata = 16'h0000;
        endcase
    end

endmodule : gr_intc
`default_nettype wire

// File: tb/tb_gr_intc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gr_intc
// Description : Self-checking bench for gr_intc. A cycle-level reference
//               model (plain arrays and loops) predicts irq_take, irq_vector
//               and reg_rdata every cycle; directed scenarios add targeted
//               checks, followed by a randomized soak. Honours
//               GR_INTC_NEST_EN for the nesting expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gr_intc;

    localparam int          NIRQ   = 8;
    localparam logic [15:0] EDGE_M = 16'h0043;   // sources 0, 1, 6 edge; rest level

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq_in;
    logic            int_en;
    logic            iret_detected;
    logic            irq_take;
    logic [15:0]     irq_vector;
    logic            reg_sel;
    logic            reg_we;
    logic [1:0]      reg_ad;
    logic [15:0]     reg_wdata;
    logic [15:0]     reg_rdata;

    always #5 clk = ~clk;

    gr_intc #(
        .NIRQ       (NIRQ),
        .EDGE       (EDGE_M),
        .VEC_BASE   (16'h0020),
        .VEC_STRIDE (16'h0004)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .int_en        (int_en),
        .iret_detected (iret_detected),
        .irq_take      (irq_take),
        .irq_vector    (irq_vector),
        .reg_sel       (reg_sel),
        .reg_we        (reg_we),
        .reg_ad        (reg_ad),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          take_cnt = 0;
    logic [15:0] take_vec = 16'h0000;
    logic [15:0] edge_v   = EDGE_M;

    // Reference model state
    bit m_pend [NIRQ];
    bit m_ins  [NIRQ];
    bit m_en   [NIRQ];
    bit m_prev [NIRQ];
    bit m_req_v;
    int m_req_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_ins();
        int lo = NIRQ;
        for (int i = NIRQ - 1; i >= 0; i--) if (m_ins[i]) lo = i;
        return lo;
    endfunction

    function automatic bit model_take();
        int lo = lowest_ins();
        bit elig;
`ifdef GR_INTC_NEST_EN
        elig = (lo == NIRQ) || (m_req_id < lo);
`else
        elig = (lo == NIRQ);
`endif
        return m_req_v && (int_en === 1'b1) && (rst === 1'b0) && elig;
    endfunction

    function automatic logic [15:0] model_rd();
        int v = 0;
        for (int i = 0; i < NIRQ; i++) begin
            if (reg_ad == 2'd0 && m_en[i])   v += (1 << i);
            if (reg_ad == 2'd1 && m_pend[i]) v += (1 << i);
            if (reg_ad == 2'd2 && m_ins[i])  v += (1 << i);
        end
        return 16'(v);
    endfunction

    // Advance the model across one clock edge using the inputs held this cycle
    function automatic void model_update(input bit take);
        bit newp [NIRQ];
        bit wr;
        int cand;
        int lo;
        if (rst) begin
            for (int i = 0; i < NIRQ; i++) begin
                m_pend[i] = 0; m_ins[i] = 0; m_en[i] = 0; m_prev[i] = 0;
            end
            m_req_v  = 0;
            m_req_id = 0;
            return;
        end
        wr   = reg_sel && reg_we;
        cand = NIRQ;
        for (int i = NIRQ - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) cand = i;
        for (int i = 0; i < NIRQ; i++) begin
            if (edge_v[i]) begin
                bit p = m_pend[i];
                if (take && i == m_req_id)                  p = 0;
                if (wr && reg_ad == 2'd1 && reg_wdata[i])   p = 0;
                if (irq_in[i] && !m_prev[i])                p = 1;
                if (wr && reg_ad == 2'd3 && reg_wdata[i])   p = 1;
                newp[i] = p;
            end else begin
                newp[i] = irq_in[i];
            end
        end
        lo = lowest_ins();
        if (iret_detected && lo < NIRQ) m_ins[lo] = 0;
        if (take) m_ins[m_req_id] = 1;
        for (int i = 0; i < NIRQ; i++) begin
            if (wr && reg_ad == 2'd0) m_en[i] = reg_wdata[i];
            m_pend[i] = newp[i];
            m_prev[i] = irq_in[i];
        end
        m_req_v  = !take && (cand < NIRQ);
        m_req_id = (cand < NIRQ) ? cand : 0;
    endfunction

    // One clock: compare outputs mid-cycle, then step the model at the edge
    task automatic cycle();
        bit          et;
        logic [15:0] ev;
        @(negedge clk);
        et = model_take();
        ev = et ? 16'(32'h20 + m_req_id * 4) : 16'h0000;
        check("irq_take", {31'd0, irq_take}, {31'd0, et});
        check("irq_vector", {16'd0, irq_vector}, {16'd0, ev});
        check("reg_rdata", {16'd0, reg_rdata}, {16'd0, model_rd()});
        if (irq_take === 1'b1) begin
            take_cnt++;
            take_vec = irq_vector;
        end
        @(posedge clk);
        model_update(et);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wr_reg(input logic [1:0] ad, input logic [15:0] d);
        reg_sel = 1'b1; reg_we = 1'b1; reg_ad = ad; reg_wdata = d;
        cycle();
        reg_sel = 1'b0; reg_we = 1'b0; reg_ad = 2'd0; reg_wdata = 16'h0000;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] ad, input logic [15:0] exp);
        reg_ad = ad;
        #1;
        check(tag, {16'd0, reg_rdata}, {16'd0, exp});
    endtask

    task automatic iret_pulse();
        iret_detected = 1'b1;
        cycle();
        iret_detected = 1'b0;
    endtask

    // Bounded wait for the next take, then check its vector
    task automatic wait_take(input string tag, input logic [15:0] exp);
        int prior = take_cnt;
        int k = 0;
        while (take_cnt == prior && k < 20) begin
            cycle();
            k++;
        end
        check({tag, "_seen"}, take_cnt - prior, 1);
        check(tag, {16'd0, take_vec}, {16'd0, exp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        rst = 1'b1; irq_in = '0; int_en = 1'b0; iret_detected = 1'b0;
        reg_sel = 1'b0; reg_we = 1'b0; reg_ad = 2'd0; reg_wdata = 16'h0000;
        run(2);
        check("rst_take", {31'd0, irq_take}, 32'd0);
        check("rst_vector", {16'd0, irq_vector}, 32'd0);
        check("rst_rdata", {16'd0, reg_rdata}, 32'd0);
        rst = 1'b0;
        run(1);

        // Level source 2: two-cycle latency to take
        int_en = 1'b1;
        wr_reg(2'd0, 16'h0004);
        irq_in[2] = 1'b1;
        n = take_cnt; lat = -1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (lat < 0 && take_cnt != n) lat = k;
        end
        check("s1_latency", lat, 2);
        check("s1_vec", {16'd0, take_vec}, 32'h0028);
        check("s1_count", take_cnt - n, 1);
        rd_check("s1_insvc", 2'd2, 16'h0004);
        irq_in = '0;
        run(3);
        iret_pulse();
        run(2);

        // Edge source 1 pulsed while masked, then released
        wr_reg(2'd0, 16'h0002);
        int_en = 1'b0;
        irq_in[1] = 1'b1;
        cycle();
        irq_in[1] = 1'b0;
        run(4);
        rd_check("s2_pending", 2'd1, 16'h0002);
        int_en = 1'b1;
        wait_take("s2_vec", 16'h0024);
        n = take_cnt;
        run(5);
        check("s2_single", take_cnt - n, 0);
        rd_check("s2_pend_clr", 2'd1, 16'h0000);
        iret_pulse();
        run(2);

        // Sources 3 and 5 together: 3 first, 5 after iret
        int_en = 1'b0;
        wr_reg(2'd0, 16'h0028);
        irq_in = 8'h28;
        run(3);
        int_en = 1'b1;
        wait_take("s3_first", 16'h002C);
        irq_in[3] = 1'b0;
        n = take_cnt;
        run(4);
        check("s3_blocked", take_cnt - n, 0);
        rd_check("s3_insvc3", 2'd2, 16'h0008);
        iret_pulse();
        wait_take("s3_second", 16'h0034);
        rd_check("s3_insvc5", 2'd2, 16'h0020);
        irq_in = '0;
        run(3);
        iret_pulse();
        run(2);

        // Source 4 in service, source 1 (edge) arrives
        wr_reg(2'd0, 16'h0012);
        irq_in[4] = 1'b1;
        wait_take("s4_src4", 16'h0030);
        irq_in[1] = 1'b1;
        cycle();
        irq_in[1] = 1'b0;
`ifdef GR_INTC_NEST_EN
        wait_take("s4_nest", 16'h0024);
        rd_check("s4_insvc", 2'd2, 16'h0012);
`else
        n = take_cnt;
        run(6);
        check("s4_blocked", take_cnt - n, 0);
        iret_pulse();
        wait_take("s4_after_iret", 16'h0024);
        rd_check("s4_insvc", 2'd2, 16'h0002);
`endif
        irq_in = '0;
        run(3);
        iret_pulse();
        iret_pulse();
        run(2);
        rd_check("s4_idle", 2'd2, 16'h0000);

        // Soft trigger on an edge source, then on a level source
        wr_reg(2'd0, 16'h0001);
        wr_reg(2'd3, 16'h0001);
        wait_take("s5_soft", 16'h0020);
        iret_pulse();
        run(2);
        wr_reg(2'd0, 16'h0004);
        n = take_cnt;
        wr_reg(2'd3, 16'h0004);
        run(3);
        rd_check("s5_level_pend", 2'd1, 16'h0000);
        rd_check("s5_soft_rd", 2'd3, 16'h0000);
        check("s5_level_notake", take_cnt - n, 0);

        // Reset one cycle after a take
        irq_in[2] = 1'b1;
        wait_take("s6_take", 16'h0028);
        rst = 1'b1;
        irq_in = '0;
        cycle();
        check("s6_rst_take", {31'd0, irq_take}, 32'd0);
        rd_check("s6_insvc", 2'd2, 16'h0000);
        rd_check("s6_pending", 2'd1, 16'h0000);
        rd_check("s6_enable", 2'd0, 16'h0000);
        cycle();
        rst = 1'b0;
        run(3);

        // Randomized soak against the model
        for (int c = 0; c < 3000; c++) begin
            logic [NIRQ-1:0] flip;
            flip = '0;
            for (int b = 0; b < NIRQ; b++) if ($urandom_range(7) == 0) flip[b] = 1'b1;
            irq_in        = irq_in ^ flip;
            int_en        = ($urandom_range(3) != 0);
            iret_detected = ($urandom_range(7) == 0);
            rst           = ($urandom_range(299) == 0);
            reg_sel       = ($urandom_range(5) == 0);
            reg_we        = 1'($urandom_range(1));
            reg_ad        = 2'($urandom_range(3));
            reg_wdata     = 16'($urandom);
            cycle();
        end
        rst = 1'b0; reg_sel = 1'b0; reg_we = 1'b0; iret_detected = 1'b0;
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gr_intc
`default_nettype wire
